hazard_detection_unit: RTL and testbench

//  Stall/flush controller for the 5-stage MIPS pipeline. It complements the EX-stage bypass logic by

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_reg_match.sv | 15 +
 rtl/hazard_detection_unit.sv | 93 +++++++++
 tb/tb_hazard_detection_unit.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    HZ_RUN  = 1'b0,
    HZ_HOLD = 1'b1
  } hz_state_e;

  localparam int REG_ZERO = 0;

  typedef logic [1:0] stall_t;
  localparam stall_t STALL_NONE = 2'd0;
  localparam stall_t STALL_ONE  = 2'd1;
  localparam stall_t STALL_TWO  = 2'd2;

  function automatic stall_t stall_max(input stall_t a, input stall_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_reg_match.sv
// Source/destination register comparator; $zero never matches. Purely combinational.
module hazard_reg_match
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src_i,
  input  logic [REG_W-1:0] dst_i,
  input  logic             en_i,
  output logic             match_o
);

  assign match_o = en_i && (src_i == dst_i) && (src_i != REG_W'(REG_ZERO));

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / ID-branch stall and branch/jump flush control; outputs are 0-cycle combinational.
// A load feeding an ID branch stalls for two cycles via HOLD. Macro HAZARD_PERF_CNT_EN adds perf counters.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_RegWrite,
  input  logic [REG_W-1:0] ID_EX_WriteReg,
  input  logic             EX_MEM_MemRead,
  input  logic [REG_W-1:0] EX_MEM_WriteReg,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  hz_state_e state_q;
  logic      rs_ex, rt_ex, rs_mem, rt_mem;
  logic      ex_hit, mem_hit;
  stall_t    need_load, need_br_ex, need_br_mem, need;
  logic      stall, flush;

  hazard_reg_match #(.REG_W(REG_W)) u_rs_ex  (.src_i(ID_Rs), .dst_i(ID_EX_WriteReg),  .en_i(1'b1),      .match_o(rs_ex));
  hazard_reg_match #(.REG_W(REG_W)) u_rt_ex  (.src_i(ID_Rt), .dst_i(ID_EX_WriteReg),  .en_i(ID_UsesRt), .match_o(rt_ex));
  hazard_reg_match #(.REG_W(REG_W)) u_rs_mem (.src_i(ID_Rs), .dst_i(EX_MEM_WriteReg), .en_i(1'b1),      .match_o(rs_mem));
  hazard_reg_match #(.REG_W(REG_W)) u_rt_mem (.src_i(ID_Rt), .dst_i(EX_MEM_WriteReg), .en_i(ID_UsesRt), .match_o(rt_mem));

  assign ex_hit  = rs_ex | rt_ex;
  assign mem_hit = rs_mem | rt_mem;

  // A branch needs a loaded value in ID, so the load must reach WB first: two bubbles.
  assign need_load   = (ID_EX_MemRead && ex_hit) ? (ID_Branch ? STALL_TWO : STALL_ONE) : STALL_NONE;
  assign need_br_ex  = (ID_Branch && ID_EX_RegWrite && !ID_EX_MemRead && ex_hit) ? STALL_ONE : STALL_NONE;
  assign need_br_mem = (ID_Branch && EX_MEM_MemRead && mem_hit) ? STALL_ONE : STALL_NONE;
  assign need        = (state_q == HZ_RUN)
                     ? stall_max(need_load, stall_max(need_br_ex, need_br_mem)) : STALL_NONE;

  assign stall = (state_q == HZ_HOLD) || (need != STALL_NONE);
  assign flush = !stall && ((ID_Branch && ID_BranchTaken) || ID_Jump);

  assign PCWrite      = !stall;
  assign IF_ID_Write  = !stall;
  assign ID_EX_Bubble = stall;
  assign IF_ID_Flush  = flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_RUN;
    end else if (state_q == HZ_RUN && need == STALL_TWO) begin
      state_q <= HZ_HOLD;
    end else begin
      state_q <= HZ_RUN;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign stall_cnt_d = stall_cnt_q + (stall ? CNT_W'(1) : CNT_W'(0));
  assign flush_cnt_d = flush_cnt_q + (flush ? CNT_W'(1) : CNT_W'(0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Table-driven scoreboard bench for hazard_detection_unit.
module tb_hazard_detection_unit;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       br;
    logic       tk;
    logic       jmp;
    logic       exmr;
    logic       exrw;
    logic [4:0] exwr;
    logic       memmr;
    logic [4:0] memwr;
  } in_t;

  typedef struct {
    in_t        in;
    logic [3:0] exp; // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}
  } vec_t;

  localparam logic [3:0] N = 4'b1100;
  localparam logic [3:0] S = 4'b0001;
  localparam logic [3:0] F = 4'b1110;

  logic        clk;
  logic        rst;
  in_t         cur;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
  logic [31:0] StallCycles, FlushCount;

  int          n_vec;
  int          n_err;
  logic [3:0]  sb[$];
  vec_t        tbl[$];
  int          exp_stalls;
  int          exp_flushes;

  hazard_detection_unit #(.REG_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(cur.rs), .ID_Rt(cur.rt), .ID_UsesRt(cur.uses),
    .ID_Branch(cur.br), .ID_BranchTaken(cur.tk), .ID_Jump(cur.jmp),
    .ID_EX_MemRead(cur.exmr), .ID_EX_RegWrite(cur.exrw), .ID_EX_WriteReg(cur.exwr),
    .EX_MEM_MemRead(cur.memmr), .EX_MEM_WriteReg(cur.memwr),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t v(input int rs, input int rt, input bit uses, input bit br,
                             input bit tk, input bit jmp, input bit exmr, input bit exrw,
                             input int exwr, input bit memmr, input int memwr,
                             input logic [3:0] e);
    vec_t r;
    r.in.rs = 5'(rs);      r.in.rt = 5'(rt);     r.in.uses = uses;
    r.in.br = br;          r.in.tk = tk;         r.in.jmp = jmp;
    r.in.exmr = exmr;      r.in.exrw = exrw;     r.in.exwr = 5'(exwr);
    r.in.memmr = memmr;    r.in.memwr = 5'(memwr);
    r.exp = e;
    return r;
  endfunction

  function automatic logic [3:0] outs();
    return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic step(input vec_t vv, input int idx);
    logic [3:0] e;
    @(posedge clk);
    #1;
    cur = vv.in;
    sb.push_back(vv.exp);
    @(negedge clk);
    e = sb.pop_front();
    n_vec++;
    if (outs() !== e) begin
      n_err++;
      $display("FAIL vec%0d outputs {pc,ifid,flush,bubble}: got %b, want %b", idx, outs(), e);
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_stalls = 0; exp_flushes = 0;
    //         rs rt u br tk j exmr exrw exwr memmr memwr exp
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N));  // idle
    tbl.push_back(v(2, 4, 1, 0, 0, 0, 1, 1, 2, 0, 0, S));  // lw $2 / add $3,$2,$4
    tbl.push_back(v(2, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2, N));  // load now in MEM
    tbl.push_back(v(2, 5, 1, 1, 1, 0, 1, 1, 2, 0, 0, S));  // lw $2 / beq $2,$5 -> HOLD
    tbl.push_back(v(1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, S));  // HOLD ignores inputs, no flush
    tbl.push_back(v(2, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, F));  // branch resolves taken
    tbl.push_back(v(2, 0, 1, 1, 1, 0, 0, 1, 2, 0, 0, S));  // add $2 / beq $2,$0
    tbl.push_back(v(2, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, F));  // then flush
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, N));  // lw $0: never a hazard
    tbl.push_back(v(1, 3, 0, 0, 0, 0, 1, 1, 3, 0, 0, N));  // Rt match, Rt unused
    tbl.push_back(v(1, 3, 1, 0, 0, 0, 1, 1, 3, 0, 0, S));  // Rt match, Rt used
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, F));  // jump
    tbl.push_back(v(2, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0, S));  // stall suppresses jump flush
    tbl.push_back(v(1, 7, 1, 1, 0, 0, 0, 0, 0, 1, 7, S));  // branch vs load in MEM
    tbl.push_back(v(1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 7, N));  // non-branch vs load in MEM
    tbl.push_back(v(4, 0, 0, 1, 0, 0, 0, 0, 4, 0, 0, N));  // EX match but no RegWrite
    tbl.push_back(v(4, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, N));  // branch not taken
    tbl.push_back(v(4, 5, 1, 0, 1, 0, 0, 0, 0, 0, 0, N));  // taken without branch
    tbl.push_back(v(9, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, N));  // ALU dep handled by bypass
    tbl.push_back(v(1, 5, 1, 1, 0, 0, 1, 1, 5, 0, 0, S));  // lw $5 / bne $1,$5 -> HOLD
    tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, S));  // HOLD suppresses jump flush
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N));  // back in RUN

    cur = '0;
    rst = 1'b1;
    #3;
    chk("reset_outputs", 32'(outs()), 32'(N));
    chk("reset_stallcycles", StallCycles, 32'd0);
    chk("reset_flushcount", FlushCount, 32'd0);
    #5;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], i);
      if (tbl[i].exp[0]) exp_stalls++;
      if (tbl[i].exp[1]) exp_flushes++;
    end

`ifdef HAZARD_PERF_CNT_EN
    chk("stallcycles_total", StallCycles, 32'(exp_stalls));
    chk("flushcount_total", FlushCount, 32'(exp_flushes));
`else
    chk("stallcycles_tied", StallCycles, 32'd0);
    chk("flushcount_tied", FlushCount, 32'd0);
`endif

    // Reset while in HOLD drops the pending stall.
    step(v(3, 8, 1, 1, 1, 0, 1, 1, 8, 0, 0, S), 100);
    @(posedge clk);
    #1;
    cur = '0;
    #1;
    chk("hold_stalls_idle", 32'(outs()), 32'(S));
    rst = 1'b1;
    #1;
    chk("rst_in_hold_outputs", 32'(outs()), 32'(N));
    chk("rst_in_hold_stallcycles", StallCycles, 32'd0);
    chk("rst_in_hold_flushcount", FlushCount, 32'd0);
    #1;
    rst = 1'b0;
    step(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, N), 101);
    step(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, F), 102);
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    chk("post_reset_flushcount", FlushCount, 32'd1);
    chk("post_reset_stallcycles", StallCycles, 32'd0);
`else
    chk("post_reset_flushcount", FlushCount, 32'd0);
    chk("post_reset_stallcycles", StallCycles, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
